pattern_scan_ctrl: RTL and testbench

Sequencing controller for the serial "101" sequence detector. It accepts a parallel word over a start/ready handshake and shifts it MSB-first into an embedded Moore detector, one bit per clock. It counts the overlapping "101" matches and reports the total with a one-cycle done pulse. It sits between a word-oriented producer and the serial detector, so software-facing logic never drives the bit stream directly.

---
 rtl/pattern_scan_pkg.sv | 42 ++++
 rtl/pattern101_fsm.sv | 39 +++
 rtl/pattern_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_scan_pkg
//  Description : Shared types for the "101" pattern scan controller and its
//                embedded serial Moore detector.
//                  - ctrl_state_t : controller states IDLE/SHIFT/FLUSH/DONE
//                  - det_state_t  : detector states S0..S3 (fixed encodings)
//                  - det_next()   : detector next-state function
//  Revision    : 1.0 - initial release
// ============================================================================
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  // S1: seen "1", S2: seen "10", S3: seen "101" (match, overlapping)
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  function automatic det_state_t det_next(input det_state_t cur, input logic x);
    det_state_t nxt;
    nxt = S0;
    case (cur)
      S0:      nxt = x ? S1 : S0;
      S1:      nxt = x ? S1 : S2;
      S2:      nxt = x ? S3 : S0;
      S3:      nxt = x ? S1 : S2;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern101_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : pattern101_fsm
//  Description : Serial Moore detector for overlapping "101" sequences.
//                Ports:
//                  clk, rst_n : clock / asynchronous active-low reset
//                  en         : advance on this edge using X
//                  clr        : force S0 (takes priority over en)
//                  X          : serial input bit
//                  Y          : high while the detector is in S3
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern101_fsm
  import pattern_scan_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic X,
  output logic Y
);

  det_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S0;
    end else if (clr) begin
      state <= S0;
    end else if (en) begin
      state <= det_next(state, X);
    end
  end

  assign Y = (state == S3);

endmodule
`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_scan_ctrl
//  Description : Accepts a WIDTH-bit word over a start/ready handshake, shifts
//                it MSB-first into a "101" detector and counts overlapping
//                matches, reporting the total with a one-cycle done pulse.
//                Ports:
//                  clk, rst_n : clock / asynchronous active-low reset
//                  start      : scan request, sampled only while ready=1
//                  data_in    : word captured on the accepting edge
//                  ready      : controller idle
//                  busy       : SHIFT or FLUSH in progress
//                  bit_out    : bit presented to the detector (0 outside SHIFT)
//                  hit        : one-cycle pulse per counted match
//                  done       : one-cycle pulse, hit_count valid from here on
//                  hit_count  : saturating match count of the last word
//                Build option: PATTERN_SCAN_CHAIN_EN keeps detector history
//                across words so matches straddling two words are counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             bit_out,
  output logic             hit,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
);

  localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  ctrl_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             det_en;
  logic             det_clr;
  logic             det_y;

  assign accept = ready && start;
  assign det_en = (state == SHIFT);

`ifdef PATTERN_SCAN_CHAIN_EN
  assign det_clr = 1'b0;
`else
  assign det_clr = accept;
`endif

  // Y at SHIFT index 0 still reflects the previous word, so it is masked.
  // In FLUSH the detector is held and Y reflects the final bit.
  assign hit     = det_y && (((state == SHIFT) && (idx != '0)) || (state == FLUSH));
  assign bit_out = (state == SHIFT) && shreg[WIDTH-1];

  pattern101_fsm u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (det_en),
    .clr   (det_clr),
    .X     (bit_out),
    .Y     (det_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      hit_count <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (hit && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            shreg     <= data_in;
            idx       <= '0;
            hit_count <= '0;
            ready     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_scan_ctrl
//  Description : Self-checking bench for pattern_scan_ctrl (WIDTH=8, CNT_W=4).
//                Expected hits are derived by searching the presented bit
//                stream for "101" windows; with PATTERN_SCAN_CHAIN_EN the
//                tail of the previous word is prepended to the stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_scan_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          ready;
  logic          busy;
  logic          bit_out;
  logic          hit;
  logic          done;
  logic [CW-1:0] hit_count;

  int checks = 0;
  int errors = 0;

  // Bits already seen by the detector that can still complete a match.
  bit hist[$];

  pattern_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .ready     (ready),
    .busy      (busy),
    .bit_out   (bit_out),
    .hit       (hit),
    .done      (done),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // eh[c] = expected hit in scan cycle c (c=0..W-1 SHIFT, c=W FLUSH)
  task automatic model(input logic [W-1:0] w, output logic [W:0] eh, output int cnt);
    bit seq[$];
    int base;
    seq  = hist;
    base = seq.size();
    for (int i = W - 1; i >= 0; i--) seq.push_back(w[i]);
    eh  = '0;
    cnt = 0;
    for (int k = 0; k < W; k++) begin
      int p;
      p = base + k;
      if (p >= 2 && seq[p-2] && !seq[p-1] && seq[p]) begin
        eh[k+1] = 1'b1;
        if (cnt < (1 << CW) - 1) cnt++;
      end
    end
    hist.delete();
`ifdef PATTERN_SCAN_CHAIN_EN
    hist.push_back(seq[seq.size()-2]);
    hist.push_back(seq[seq.size()-1]);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_bit"},   bit_out, 0);
    check({tag, "_hit"},   hit, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_cnt"},   hit_count, 0);
  endtask

  // Called at a negedge with the controller idle; returns at a negedge idle.
  task automatic scan(input logic [W-1:0] w, input bit poke);
    logic [W:0] eh;
    int cnt;
    int run;
    model(w, eh, cnt);
    check("idle_ready", ready, 1);
    start   = 1'b1;
    data_in = w;
    @(negedge clk);
    start   = 1'b0;
    data_in = W'($urandom);
    run     = 0;
    for (int k = 0; k < W; k++) begin
      check($sformatf("sh%0d_ready", k), ready, 0);
      check($sformatf("sh%0d_busy", k), busy, 1);
      check($sformatf("sh%0d_bit", k), bit_out, w[W-1-k]);
      check($sformatf("sh%0d_hit", k), hit, eh[k]);
      check($sformatf("sh%0d_cnt", k), hit_count, run);
      check($sformatf("sh%0d_done", k), done, 0);
      run += int'(eh[k]);
      if (poke && k == 2) begin
        start   = 1'b1;
        data_in = ~w;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("fl_busy", busy, 1);
    check("fl_ready", ready, 0);
    check("fl_bit", bit_out, 0);
    check("fl_hit", hit, eh[W]);
    check("fl_done", done, 0);
    @(negedge clk);
    check("dn_done", done, 1);
    check("dn_busy", busy, 0);
    check("dn_ready", ready, 0);
    check("dn_hit", hit, 0);
    check("dn_cnt", hit_count, cnt);
    @(negedge clk);
    check("id_ready", ready, 1);
    check("id_done", done, 0);
    check("id_cnt", hit_count, cnt);
  endtask

  initial begin
    logic [W:0] eh_dummy;
    int         cnt_dummy;
    int         t1;
    int         t2;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    scan(8'b1010_0000, 1'b0);
    scan(8'b1010_1010, 1'b0);
    scan(8'b0000_0101, 1'b0);
    scan(8'h00, 1'b0);
    scan(8'b0000_0010, 1'b0);
    scan(8'b1000_0000, 1'b0);
    scan(8'b0101_1010, 1'b1);

    // Reset in SHIFT k=4: immediate reset values, no done pulse.
    model(8'b1010_0000, eh_dummy, cnt_dummy);
    start   = 1'b1;
    data_in = 8'b1010_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    hist.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid_nodone%0d", c), done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rel");
    scan(8'b1010_0000, 1'b0);

    for (int n = 0; n < 40; n++) begin
      scan(W'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Throughput with start held high: done pulses every W+3 cycles.
    start   = 1'b1;
    data_in = '0;
    t1 = -1;
    t2 = -1;
    for (int c = 0; c < 60 && t2 < 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) t1 = c;
        else        t2 = c;
      end
    end
    check("throughput", t2 - t1, W + 3);
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
